// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
// Shared types and helpers for the reorder-buffer commit unit.
//   ROB_DATA_W  : width of the result data held in each entry
//   REG_ZERO    : architectural register hard-wired to zero (never written)
//   rob_entry_t : one ROB slot {valid, done, reg_write, dest, data}
//   tag_width() : bits needed for tags 0..size (0 = "value in register file")
// ---------------------------------------------------------------------------
package rob_pkg;

   localparam int         ROB_DATA_W = 32;
   localparam logic [4:0] REG_ZERO   = 5'd31;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  reg_write;
      logic [4:0]            dest;
      logic [ROB_DATA_W-1:0] data;
   } rob_entry_t;

   // Tag 0 is reserved, so tags span 0..size inclusive.
   function automatic int tag_width(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/rob_ptr.sv
// ---------------------------------------------------------------------------
// rob_ptr
// Wrapping pointer register counting 0..SIZE-1 and wrapping back to 0.
// Ports:
//   clk     : clock, updates on posedge
//   reset   : synchronous, active-high; returns the pointer to 0
//   advance : step the pointer by one on the next edge
//   ptr     : current pointer value
// ---------------------------------------------------------------------------
module rob_ptr #(
   parameter  int SIZE  = 8,
   localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             advance,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   // Next pointer: increment with explicit wrap so non-power-of-two sizes work.
   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         if (ptr_q == PTR_W'(SIZE - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = ptr_q + PTR_W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/rob_commit_unit.sv
// ---------------------------------------------------------------------------
// rob_commit_unit
// Reorder buffer with in-order commit. Hands rename tags to decode, records
// execution results, and retires the oldest entry to the register file while
// clearing the map-table entry if it still points at the retiring tag.
// Ports:
//   clk, reset                   : clock; synchronous active-high reset
//   alloc_valid_i/_reg_write_i/_dest_i : allocation request from decode
//   alloc_ready_o, alloc_tag_o   : entry available / tag for the accepted alloc
//   complete_valid_i/_tag_i/_data_i    : execution result write-back
//   commit_read_addr_o           : map table commit read address (head dest)
//   commit_map_data_i            : map table current mapping of head dest
//   map_resets_o                 : one-hot map table clear
//   rf_write_en_o/_addr_o/_data_o      : register file write port
//   rob_count_o                  : occupied entries, 0..ROB_SIZE
// Tags are entry index + 1; tag 0 means "value lives in the register file".
// DATA_W must match rob_pkg::ROB_DATA_W since entries store ROB_DATA_W bits.
// ---------------------------------------------------------------------------
module rob_commit_unit
   import rob_pkg::*;
#(
   parameter int ROB_SIZE = 8,
   parameter int TAG_W    = tag_width(ROB_SIZE),
   parameter int DATA_W   = ROB_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_valid_i,
   input  logic              alloc_reg_write_i,
   input  logic [4:0]        alloc_dest_i,
   output logic              alloc_ready_o,
   output logic [TAG_W-1:0]  alloc_tag_o,
   input  logic              complete_valid_i,
   input  logic [TAG_W-1:0]  complete_tag_i,
   input  logic [DATA_W-1:0] complete_data_i,
   output logic [4:0]        commit_read_addr_o,
   input  logic [TAG_W-1:0]  commit_map_data_i,
   output logic [31:0]       map_resets_o,
   output logic              rf_write_en_o,
   output logic [4:0]        rf_write_addr_o,
   output logic [DATA_W-1:0] rf_write_data_o,
   output logic [TAG_W-1:0]  rob_count_o
);

   localparam int               PTR_W    = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
   localparam logic [TAG_W-1:0] SIZE_TAG = TAG_W'(ROB_SIZE);

   rob_entry_t       entries_q [ROB_SIZE];
   rob_entry_t       entries_d [ROB_SIZE];
   logic [TAG_W-1:0] count_q;
   logic [TAG_W-1:0] count_d;

   logic [PTR_W-1:0] head_s;
   logic [PTR_W-1:0] tail_s;
   logic [TAG_W-1:0] head_tag_s;
   rob_entry_t       head_entry_s;
   logic             alloc_ready_s;
   logic             accept_s;
   logic             commit_fire_s;
   logic             cmpl_hit_s;
   logic [PTR_W-1:0] cmpl_idx_s;

   rob_ptr #(.SIZE(ROB_SIZE)) u_head_ptr (
      .clk     (clk),
      .reset   (reset),
      .advance (commit_fire_s),
      .ptr     (head_s)
   );

   rob_ptr #(.SIZE(ROB_SIZE)) u_tail_ptr (
      .clk     (clk),
      .reset   (reset),
      .advance (accept_s),
      .ptr     (tail_s)
   );

   // Allocation handshake. Readiness looks only at the registered count, so a
   // full ROB refuses allocation even while it is retiring its head.
   always_comb begin
      alloc_ready_s = (count_q != SIZE_TAG);
      accept_s      = alloc_valid_i & alloc_ready_s;
      head_tag_s    = TAG_W'(head_s) + TAG_W'(1);
      if (reset) begin
         alloc_ready_o = 1'b1;
         alloc_tag_o   = TAG_W'(1);
         rob_count_o   = '0;
      end else begin
         alloc_ready_o = alloc_ready_s;
         alloc_tag_o   = TAG_W'(tail_s) + TAG_W'(1);
         rob_count_o   = count_q;
      end
   end

   // Completion decode. The range check matters: an out-of-range tag would
   // otherwise truncate onto a real entry index.
   always_comb begin
      cmpl_idx_s = '0;
      cmpl_hit_s = 1'b0;
      if (complete_valid_i && (complete_tag_i != '0) && (complete_tag_i <= SIZE_TAG)) begin
         cmpl_idx_s = PTR_W'(complete_tag_i - TAG_W'(1));
         cmpl_hit_s = entries_q[cmpl_idx_s].valid;
      end else begin
         cmpl_idx_s = '0;
         cmpl_hit_s = 1'b0;
      end
   end

   // Per-entry next state. Retire wins over a same-cycle re-completion of the
   // head; allocate never collides with either because its slot is free.
   always_comb begin
      for (int i = 0; i < ROB_SIZE; i++) begin
         entries_d[i] = entries_q[i];
         if (commit_fire_s && (head_s == PTR_W'(i))) begin
            entries_d[i].valid = 1'b0;
            entries_d[i].done  = 1'b0;
         end else if (accept_s && (tail_s == PTR_W'(i))) begin
            entries_d[i].valid     = 1'b1;
            entries_d[i].done      = 1'b0;
            entries_d[i].reg_write = alloc_reg_write_i;
            entries_d[i].dest      = alloc_dest_i;
         end else if (cmpl_hit_s && (cmpl_idx_s == PTR_W'(i))) begin
            entries_d[i].done = 1'b1;
            entries_d[i].data = complete_data_i;
         end else begin
            entries_d[i] = entries_q[i];
         end
      end
   end

   // Entry array. Only valid/done need reset; payload is qualified by valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
         if (reset) begin
            entries_q[i].valid <= 1'b0;
            entries_q[i].done  <= 1'b0;
         end else begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

   // Occupancy: allocate and commit in the same cycle cancel out.
   always_comb begin
      count_d = count_q + TAG_W'(accept_s) - TAG_W'(commit_fire_s);
   end

   // Occupancy register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Commit and map-clear. The map entry is cleared only if it still names the
   // retiring tag; a younger rename of the same register must survive.
   always_comb begin
      head_entry_s       = entries_q[head_s];
      commit_fire_s      = head_entry_s.valid & head_entry_s.done;
      commit_read_addr_o = 5'd0;
      rf_write_en_o      = 1'b0;
      rf_write_addr_o    = 5'd0;
      rf_write_data_o    = '0;
      map_resets_o       = 32'h0000_0000;
      if (reset) begin
         commit_read_addr_o = 5'd0;
         rf_write_addr_o    = 5'd0;
      end else if (head_entry_s.valid) begin
         commit_read_addr_o = head_entry_s.dest;
         rf_write_addr_o    = head_entry_s.dest;
         rf_write_data_o    = head_entry_s.data;
         if (commit_fire_s && head_entry_s.reg_write && (head_entry_s.dest != REG_ZERO)) begin
            rf_write_en_o = 1'b1;
            if (commit_map_data_i == head_tag_s) begin
               map_resets_o = 32'h0000_0001 << head_entry_s.dest;
            end else begin
               map_resets_o = 32'h0000_0000;
            end
         end else begin
            rf_write_en_o = 1'b0;
         end
      end else begin
         commit_read_addr_o = 5'd0;
      end
   end

endmodule

// File: tb/tb_rob_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_rob_commit_unit
// Directed bench for rob_commit_unit (ROB_SIZE=8). Expected commits are
// queued when the completing result is driven and compared when the commit
// cycle arrives.
// ---------------------------------------------------------------------------
module tb_rob_commit_unit;

   localparam int ROB_SIZE = 8;
   localparam int TAG_W    = 4;
   localparam int DATA_W   = 32;

   logic              clk;
   logic              reset;
   logic              alloc_valid_i;
   logic              alloc_reg_write_i;
   logic [4:0]        alloc_dest_i;
   logic              alloc_ready_o;
   logic [TAG_W-1:0]  alloc_tag_o;
   logic              complete_valid_i;
   logic [TAG_W-1:0]  complete_tag_i;
   logic [DATA_W-1:0] complete_data_i;
   logic [4:0]        commit_read_addr_o;
   logic [TAG_W-1:0]  commit_map_data_i;
   logic [31:0]       map_resets_o;
   logic              rf_write_en_o;
   logic [4:0]        rf_write_addr_o;
   logic [DATA_W-1:0] rf_write_data_o;
   logic [TAG_W-1:0]  rob_count_o;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] map;
   } commit_exp_t;

   commit_exp_t sb_q [$];
   int tests    = 0;
   int failures = 0;

   rob_commit_unit #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .alloc_valid_i      (alloc_valid_i),
      .alloc_reg_write_i  (alloc_reg_write_i),
      .alloc_dest_i       (alloc_dest_i),
      .alloc_ready_o      (alloc_ready_o),
      .alloc_tag_o        (alloc_tag_o),
      .complete_valid_i   (complete_valid_i),
      .complete_tag_i     (complete_tag_i),
      .complete_data_i    (complete_data_i),
      .commit_read_addr_o (commit_read_addr_o),
      .commit_map_data_i  (commit_map_data_i),
      .map_resets_o       (map_resets_o),
      .rf_write_en_o      (rf_write_en_o),
      .rf_write_addr_o    (rf_write_addr_o),
      .rf_write_data_o    (rf_write_data_o),
      .rob_count_o        (rob_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_commit(input logic en, input logic [4:0] addr,
                              input logic [31:0] data, input logic [31:0] map);
      commit_exp_t e;
      e.en   = en;
      e.addr = addr;
      e.data = data;
      e.map  = map;
      sb_q.push_back(e);
   endtask

   // Pops the oldest expected commit and compares it with the commit port.
   task automatic check_commit(input string name);
      commit_exp_t e;
      if (sb_q.size() == 0) begin
         tests++;
         failures++;
         $error("FAIL %s: observed empty scoreboard expected a queued commit", name);
      end else begin
         e = sb_q.pop_front();
         chk({name, "_en"},   {31'd0, rf_write_en_o}, {31'd0, e.en});
         chk({name, "_addr"}, {27'd0, rf_write_addr_o}, {27'd0, e.addr});
         chk({name, "_data"}, rf_write_data_o, e.data);
         chk({name, "_map"},  map_resets_o, e.map);
      end
   endtask

   task automatic idle_inputs();
      alloc_valid_i     = 1'b0;
      alloc_reg_write_i = 1'b0;
      alloc_dest_i      = 5'd0;
      complete_valid_i  = 1'b0;
      complete_tag_i    = 4'd0;
      complete_data_i   = 32'd0;
      commit_map_data_i = 4'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] dest, input logic [3:0] exp_tag);
      alloc_valid_i     = 1'b1;
      alloc_reg_write_i = 1'b1;
      alloc_dest_i      = dest;
      #1;
      chk("alloc_ready", {31'd0, alloc_ready_o}, 32'd1);
      chk("alloc_tag",   {28'd0, alloc_tag_o}, {28'd0, exp_tag});
      step();
      alloc_valid_i = 1'b0;
   endtask

   task automatic complete(input logic [3:0] tag, input logic [31:0] data, input logic [3:0] map_data);
      complete_valid_i  = 1'b1;
      complete_tag_i    = tag;
      complete_data_i   = data;
      commit_map_data_i = map_data;
      step();
      complete_valid_i = 1'b0;
   endtask

   initial begin
      // Reset values, both while reset is held and right after it.
      idle_inputs();
      reset = 1'b1;
      #1;
      chk("rst_ready", {31'd0, alloc_ready_o}, 32'd1);
      chk("rst_tag",   {28'd0, alloc_tag_o}, 32'd1);
      chk("rst_count", {28'd0, rob_count_o}, 32'd0);
      chk("rst_rf_en", {31'd0, rf_write_en_o}, 32'd0);
      chk("rst_map",   map_resets_o, 32'h0);
      step();
      reset = 1'b0;
      #1;
      chk("post_rst_tag",   {28'd0, alloc_tag_o}, 32'd1);
      chk("post_rst_count", {28'd0, rob_count_o}, 32'd0);
      chk("post_rst_raddr", {27'd0, commit_read_addr_o}, 32'd0);

      // Single entry: allocate, complete, commit with map clear.
      alloc(5'd5, 4'd1);
      chk("one_count", {28'd0, rob_count_o}, 32'd1);
      push_commit(1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_0020);
      complete_valid_i  = 1'b1;
      complete_tag_i    = 4'd1;
      complete_data_i   = 32'hDEAD_BEEF;
      commit_map_data_i = 4'd1;
      #1;
      chk("one_no_early_commit", {31'd0, rf_write_en_o}, 32'd0);
      step();
      complete_valid_i = 1'b0;
      #1;
      check_commit("one");
      chk("one_raddr", {27'd0, commit_read_addr_o}, 32'd5);
      step();
      chk("one_count_after", {28'd0, rob_count_o}, 32'd0);
      chk("one_rf_en_after", {31'd0, rf_write_en_o}, 32'd0);

      // Same destination renamed twice: older commit must not clear the map.
      do_reset();
      alloc(5'd5, 4'd1);
      alloc(5'd5, 4'd2);
      push_commit(1'b1, 5'd5, 32'h0000_00A1, 32'h0);
      complete(4'd1, 32'h0000_00A1, 4'd2);
      #1;
      check_commit("younger_map");
      step();
      push_commit(1'b1, 5'd5, 32'h0000_00B2, 32'h0000_0020);
      complete(4'd2, 32'h0000_00B2, 4'd2);
      #1;
      check_commit("second_map");
      step();
      chk("two_count_after", {28'd0, rob_count_o}, 32'd0);

      // Fill the ROB, refuse a 9th, out-of-order completion, wrap.
      do_reset();
      for (int i = 0; i < ROB_SIZE; i++) begin
         alloc(5'(i + 1), 4'(i + 1));
      end
      alloc_valid_i = 1'b1;
      alloc_dest_i  = 5'd20;
      #1;
      chk("full_ready", {31'd0, alloc_ready_o}, 32'd0);
      chk("full_count", {28'd0, rob_count_o}, 32'd8);
      step();
      alloc_valid_i = 1'b0;
      chk("ninth_ignored", {28'd0, rob_count_o}, 32'd8);
      complete(4'd8, 32'h8888_0008, 4'd8);
      #1;
      chk("tail_done_no_commit", {31'd0, rf_write_en_o}, 32'd0);
      chk("tail_done_count", {28'd0, rob_count_o}, 32'd8);
      push_commit(1'b1, 5'd1, 32'h1111_0001, 32'h0000_0002);
      complete(4'd1, 32'h1111_0001, 4'd1);
      alloc_valid_i = 1'b1;
      #1;
      check_commit("full_commit");
      chk("full_commit_ready", {31'd0, alloc_ready_o}, 32'd0);
      step();
      alloc_valid_i = 1'b0;
      chk("after_full_count", {28'd0, rob_count_o}, 32'd7);
      chk("after_full_ready", {31'd0, alloc_ready_o}, 32'd1);
      chk("wrap_tag",         {28'd0, alloc_tag_o}, 32'd1);
      chk("only_one_commit",  {31'd0, rf_write_en_o}, 32'd0);

      // Register 31 retires without a write; bad tags are ignored.
      do_reset();
      alloc(5'd31, 4'd1);
      complete(4'd9, 32'h9999_9999, 4'd1);
      #1;
      chk("tag9_ignored", {28'd0, rob_count_o}, 32'd1);
      chk("tag9_no_fire", {31'd0, rf_write_en_o}, 32'd0);
      chk("r31_raddr", {27'd0, commit_read_addr_o}, 32'd31);
      step();
      chk("tag9_still_1", {28'd0, rob_count_o}, 32'd1);
      complete(4'd0, 32'h0000_0000, 4'd1);
      step();
      chk("tag0_ignored", {28'd0, rob_count_o}, 32'd1);
      push_commit(1'b0, 5'd31, 32'h3131_3131, 32'h0);
      complete(4'd1, 32'h3131_3131, 4'd1);
      #1;
      check_commit("r31");
      step();
      chk("r31_retired", {28'd0, rob_count_o}, 32'd0);

      // Reset mid-flight discards all entries.
      do_reset();
      alloc(5'd2, 4'd1);
      alloc(5'd3, 4'd2);
      alloc(5'd4, 4'd3);
      chk("inflight_count", {28'd0, rob_count_o}, 32'd3);
      reset = 1'b1;
      #1;
      chk("midrst_count", {28'd0, rob_count_o}, 32'd0);
      chk("midrst_tag",   {28'd0, alloc_tag_o}, 32'd1);
      step();
      reset = 1'b0;
      #1;
      chk("postmid_count", {28'd0, rob_count_o}, 32'd0);
      chk("postmid_tag",   {28'd0, alloc_tag_o}, 32'd1);
      complete(4'd2, 32'h2222_2222, 4'd2);
      #1;
      chk("late_cmpl_count", {28'd0, rob_count_o}, 32'd0);
      chk("late_cmpl_rf_en", {31'd0, rf_write_en_o}, 32'd0);
      chk("late_cmpl_raddr", {27'd0, commit_read_addr_o}, 32'd0);

      chk("scoreboard_drained", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
